// File: rtl/vc_dest_scheduler.sv
// rtl/vc_dest_scheduler.sv - weighted VC0/VC1 to D0/D1 scheduler with almost-full back-pressure
module vc_dest_scheduler #(
    parameter int DATA_W   = 6,
    parameter int DEST_BIT = 4,
    parameter int WEIGHT   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              vc0_empty,
    input  logic              vc1_empty,
    input  logic [DATA_W-1:0] vc0_data,
    input  logic [DATA_W-1:0] vc1_data,
    input  logic              d0_almost_full,
    input  logic              d1_almost_full,
    output logic              pop_vc0,
    output logic              pop_vc1,
    output logic              push_d0,
    output logic              push_d1,
    output logic [DATA_W-1:0] data_out,
    output logic              sched_idle,
    output logic              hol_blocked
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [3:0] WEIGHT_L = 4'(WEIGHT);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              push_d0_q, push_d1_q;
    logic [DATA_W-1:0] data_out_q;
    logic              sched_idle_q;
    logic              hol_blocked_q;

    logic              run;
    logic              elig0, elig1;
    logic              grant0, grant1, any_grant;
    logic              blocked;
    logic [DATA_W-1:0] gnt_word;

    // Eligibility uses almost_full because the push lands one cycle after the pop.
    always_comb begin
        run    = (state_q == ST_RUN);
        elig0  = !vc0_empty && !(vc0_data[DEST_BIT] ? d1_almost_full : d0_almost_full);
        elig1  = !vc1_empty && !(vc1_data[DEST_BIT] ? d1_almost_full : d0_almost_full);
        // VC1 only wins a contested cycle once VC0 has used up its weight.
        grant0 = run && elig0 && (!elig1 || (cnt_q != WEIGHT_L));
        grant1 = run && elig1 && !grant0;
        any_grant = grant0 || grant1;
        gnt_word  = grant1 ? vc1_data : vc0_data;
        blocked   = (!vc0_empty && !elig0) || (!vc1_empty && !elig1);
        pop_vc0   = grant0 && !reset;
        pop_vc1   = grant1 && !reset;
    end

    // Control FSM: RUN grants even in the cycle enable drops, DRAIN lets that push land.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable) state_d = ST_RUN;
            ST_RUN:   if (!enable) state_d = ST_DRAIN;
            ST_DRAIN: state_d = enable ? ST_RUN : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Weight counter: counts VC0 wins over a waiting VC1, saturating at WEIGHT.
    always_comb begin
        cnt_d = cnt_q;
        if (!elig1 || grant1) begin
            cnt_d = 4'd0;
        end else if (grant0 && (cnt_q < WEIGHT_L)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // State and registered outputs; reset cancels any in-flight push.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 4'd0;
            push_d0_q     <= 1'b0;
            push_d1_q     <= 1'b0;
            data_out_q    <= '0;
            sched_idle_q  <= 1'b1;
            hol_blocked_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            push_d0_q     <= any_grant && !gnt_word[DEST_BIT];
            push_d1_q     <= any_grant && gnt_word[DEST_BIT];
            if (any_grant) begin
                data_out_q <= gnt_word;
            end
            sched_idle_q  <= (state_q == ST_IDLE) && vc0_empty && vc1_empty;
            hol_blocked_q <= run && !any_grant && blocked;
        end
    end

    assign push_d0     = push_d0_q;
    assign push_d1     = push_d1_q;
    assign data_out    = data_out_q;
    assign sched_idle  = sched_idle_q;
    assign hol_blocked = hol_blocked_q;

endmodule

// File: tb/tb_vc_dest_scheduler.sv
// tb/tb_vc_dest_scheduler.sv - vector table, weighted sequence and random model check for vc_dest_scheduler
module tb_vc_dest_scheduler;

    localparam int DW = 6;
    localparam int WT = 3;

    logic          clk = 1'b0;
    logic          reset, enable, vc0_empty, vc1_empty;
    logic [DW-1:0] vc0_data, vc1_data;
    logic          d0_almost_full, d1_almost_full;
    logic          pop_vc0, pop_vc1, push_d0, push_d1, sched_idle, hol_blocked;
    logic [DW-1:0] data_out;

    int checks = 0;
    int errors = 0;

    vc_dest_scheduler #(.DATA_W(DW), .DEST_BIT(4), .WEIGHT(WT)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
        .vc0_data(vc0_data), .vc1_data(vc1_data),
        .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
        .pop_vc0(pop_vc0), .pop_vc1(pop_vc1), .push_d0(push_d0), .push_d1(push_d1),
        .data_out(data_out), .sched_idle(sched_idle), .hol_blocked(hol_blocked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst, en, e0, e1;
        logic [DW-1:0] d0, d1;
        logic af0, af1;
        logic p0, p1, q0, q1;
        logic [DW-1:0] dout;
        logic idle, hol;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic en, logic e0, logic e1, logic [DW-1:0] d0,
                                logic [DW-1:0] d1, logic af0, logic af1, logic p0, logic p1,
                                logic q0, logic q1, logic [DW-1:0] dout, logic idle, logic hol);
        vec_t v;
        v.rst = rst; v.en = en; v.e0 = e0; v.e1 = e1; v.d0 = d0; v.d1 = d1;
        v.af0 = af0; v.af1 = af1; v.p0 = p0; v.p1 = p1; v.q0 = q0; v.q1 = q1;
        v.dout = dout; v.idle = idle; v.hol = hol;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: VC FIFOs as queues, scheduler as plain rules.
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int            m_state;   // 0 idle, 1 run, 2 drain
    int            m_cnt;
    logic          m_push0, m_push1, m_idle, m_hol;
    logic [DW-1:0] m_data;
    int            gnt_log[$];

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_push0 = 0; m_push1 = 0;
        m_data = '0; m_idle = 1; m_hol = 0;
    endtask

    task automatic do_reset();
        reset = 1; enable = 0; vc0_empty = 1; vc1_empty = 1;
        d0_almost_full = 0; d1_almost_full = 0;
        @(posedge clk); #1;
        model_reset();
    endtask

    task automatic mcycle(input logic rst_i, input logic en_i, input logic af0_i, input logic af1_i);
        bit e0, e1, el0, el1, g0, g1, blk;
        logic [DW-1:0] w;
        e0 = (q0.size() == 0);
        e1 = (q1.size() == 0);
        reset = rst_i; enable = en_i; d0_almost_full = af0_i; d1_almost_full = af1_i;
        vc0_empty = e0; vc1_empty = e1;
        vc0_data = e0 ? DW'($urandom) : q0[0];
        vc1_data = e1 ? DW'($urandom) : q1[0];
        el0 = !e0 && !(vc0_data[4] ? af1_i : af0_i);
        el1 = !e1 && !(vc1_data[4] ? af1_i : af0_i);
        g0 = !rst_i && (m_state == 1) && el0 && (!el1 || m_cnt < WT);
        g1 = !rst_i && (m_state == 1) && el1 && !g0;
        blk = (!e0 && !el0) || (!e1 && !el1);
        @(negedge clk);
        chk("pop_vc0", pop_vc0, g0);
        chk("pop_vc1", pop_vc1, g1);
        chk("push_d0", push_d0, m_push0);
        chk("push_d1", push_d1, m_push1);
        chk("data_out", data_out, m_data);
        chk("sched_idle", sched_idle, m_idle);
        chk("hol_blocked", hol_blocked, m_hol);
        if (pop_vc0 === 1'b1) gnt_log.push_back(0);
        if (pop_vc1 === 1'b1) gnt_log.push_back(1);
        if (rst_i) begin
            model_reset();
        end else begin
            w = g1 ? vc1_data : vc0_data;
            m_idle  = (m_state == 0) && e0 && e1;
            m_hol   = (m_state == 1) && !(g0 || g1) && blk;
            m_push0 = (g0 || g1) && !w[4];
            m_push1 = (g0 || g1) && w[4];
            if (g0 || g1) m_data = w;
            if (!el1 || g1) m_cnt = 0;
            else if (g0) m_cnt = (m_cnt + 1 > WT) ? WT : m_cnt + 1;
            if (m_state == 0) m_state = en_i ? 1 : 0;
            else if (m_state == 1) m_state = en_i ? 1 : 2;
            else m_state = en_i ? 1 : 0;
            if (g0) void'(q0.pop_front());
            if (g1) void'(q1.pop_front());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1; enable = 1; vc0_empty = 0; vc1_empty = 0;
        vc0_data = 6'h01; vc1_data = 6'h03; d0_almost_full = 0; d1_almost_full = 0;
        @(posedge clk); #1;

        //            rst en e0 e1 d0     d1     af0 af1 p0 p1 q0 q1 dout   idle hol
        tbl.push_back(mk(1, 1, 0, 0, 6'h01, 6'h03, 0, 0, 0, 0, 0, 0, 6'h00, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 6'h01, 6'h03, 0, 0, 0, 0, 0, 0, 6'h00, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 6'h01, 6'h00, 0, 0, 0, 0, 0, 0, 6'h00, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 6'h01, 6'h00, 0, 0, 1, 0, 0, 0, 6'h00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 6'h02, 6'h00, 0, 0, 1, 0, 1, 0, 6'h01, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 6'h03, 6'h00, 0, 0, 1, 0, 1, 0, 6'h02, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 6'h04, 6'h00, 0, 0, 1, 0, 1, 0, 6'h03, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 6'h05, 6'h00, 0, 0, 1, 0, 1, 0, 6'h04, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 6'h00, 6'h00, 0, 0, 0, 0, 1, 0, 6'h05, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 6'h00, 6'h00, 0, 0, 0, 0, 0, 0, 6'h05, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 6'h12, 6'h03, 0, 1, 0, 1, 0, 0, 6'h05, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 6'h12, 6'h00, 0, 1, 0, 0, 1, 0, 6'h03, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 6'h12, 6'h00, 0, 1, 0, 0, 0, 0, 6'h03, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 6'h12, 6'h00, 0, 0, 1, 0, 0, 0, 6'h03, 0, 1));
        tbl.push_back(mk(0, 1, 1, 1, 6'h00, 6'h00, 0, 0, 0, 0, 0, 1, 6'h12, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 6'h07, 6'h00, 0, 0, 1, 0, 0, 0, 6'h12, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 6'h00, 6'h00, 0, 0, 0, 0, 1, 0, 6'h07, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 6'h00, 6'h00, 0, 0, 0, 0, 0, 0, 6'h07, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 6'h00, 6'h00, 0, 0, 0, 0, 0, 0, 6'h07, 1, 0));
        tbl.push_back(mk(0, 1, 1, 1, 6'h00, 6'h00, 0, 0, 0, 0, 0, 0, 6'h07, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 6'h08, 6'h00, 0, 0, 1, 0, 0, 0, 6'h07, 1, 0));
        tbl.push_back(mk(1, 1, 0, 1, 6'h09, 6'h00, 0, 0, 0, 0, 1, 0, 6'h08, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 6'h09, 6'h00, 0, 0, 0, 0, 0, 0, 6'h00, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 6'h09, 6'h00, 0, 0, 1, 0, 0, 0, 6'h00, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 6'h00, 6'h00, 0, 0, 0, 0, 1, 0, 6'h09, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 6'h01, 6'h13, 1, 1, 0, 0, 0, 0, 6'h09, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 6'h01, 6'h13, 0, 0, 1, 0, 0, 0, 6'h09, 0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst; enable = tbl[i].en;
            vc0_empty = tbl[i].e0; vc1_empty = tbl[i].e1;
            vc0_data = tbl[i].d0; vc1_data = tbl[i].d1;
            d0_almost_full = tbl[i].af0; d1_almost_full = tbl[i].af1;
            @(negedge clk);
            chk($sformatf("tbl%0d_pop_vc0", i), pop_vc0, tbl[i].p0);
            chk($sformatf("tbl%0d_pop_vc1", i), pop_vc1, tbl[i].p1);
            chk($sformatf("tbl%0d_push_d0", i), push_d0, tbl[i].q0);
            chk($sformatf("tbl%0d_push_d1", i), push_d1, tbl[i].q1);
            chk($sformatf("tbl%0d_data_out", i), data_out, tbl[i].dout);
            chk($sformatf("tbl%0d_sched_idle", i), sched_idle, tbl[i].idle);
            chk($sformatf("tbl%0d_hol", i), hol_blocked, tbl[i].hol);
            @(posedge clk); #1;
        end

        // Weighted arbitration: 8 words in each VC, no back-pressure.
        do_reset();
        q0.delete(); q1.delete(); gnt_log.delete();
        for (int i = 0; i < 8; i++) begin
            q0.push_back(DW'(i));
            q1.push_back(DW'(6'h10 + i));
        end
        for (int c = 0; c < 40 && gnt_log.size() < 16; c++) mcycle(0, 1, 0, 0);
        chk("wgt_grant_count", 8'(gnt_log.size()), 8'd16);
        for (int i = 0; i < 8; i++) begin
            if (i < gnt_log.size()) chk($sformatf("wgt_grant%0d", i), 8'(gnt_log[i]), (i % 4 == 3) ? 8'd1 : 8'd0);
        end
        for (int c = 0; c < 3; c++) mcycle(0, 1, 0, 0);

        // Randomized traffic against the model.
        do_reset();
        q0.delete(); q1.delete();
        for (int c = 0; c < 800; c++) begin
            if (q0.size() < 4 && $urandom_range(0, 1) == 0) q0.push_back(DW'($urandom));
            if (q1.size() < 4 && $urandom_range(0, 1) == 0) q1.push_back(DW'($urandom));
            mcycle($urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
